// File: rtl/i2c_slave_teddy.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, 7-bit address match,
// byte receive with ACK and byte transmit with master ACK/NACK handling.
module i2c_slave_teddy #(
    parameter logic [6:0] DEV_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    output logic       sda_oen,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic [7:0] rx_data,
    output logic       rx_ena,
    output logic       rw,
    output logic       start_det,
    output logic       stop_det,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, GET_ADDR, ACK_ADDR, RX_BYTE, ACK_RX, TX_BYTE, WAIT_ACK
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  scl_sync_q, sda_sync_q;
    logic        scl_prev_q, sda_prev_q;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic        phase_q, phase_d;
    logic        oen_q, oen_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_ena_q, rx_ena_d;
    logic        tx_req_q, tx_req_d;
    logic        rw_q, rw_d;
    logic        start_q, start_d;
    logic        stop_q, stop_d;
    logic        busy_q, busy_d;

    logic        scl_s, sda_s, scl_rise, scl_fall, start_ev, stop_ev;
    logic [7:0]  in_byte;

    assign scl_s    = scl_sync_q[1];
    assign sda_s    = sda_sync_q[1];
    assign scl_rise = scl_s & ~scl_prev_q;
    assign scl_fall = ~scl_s & scl_prev_q;
    assign start_ev = scl_s & scl_prev_q & ~sda_s & sda_prev_q;
    assign stop_ev  = scl_s & scl_prev_q & sda_s & ~sda_prev_q;
    assign in_byte  = {shift_q[6:0], sda_s};

    // Sync and previous-sample registers reset to 1 so an idle bus shows no edge.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            phase_q    <= 1'b0;
            oen_q      <= 1'b0;
            rx_data_q  <= '0;
            rx_ena_q   <= 1'b0;
            tx_req_q   <= 1'b0;
            rw_q       <= 1'b0;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            phase_q    <= phase_d;
            oen_q      <= oen_d;
            rx_data_q  <= rx_data_d;
            rx_ena_q   <= rx_ena_d;
            tx_req_q   <= tx_req_d;
            rw_q       <= rw_d;
            start_q    <= start_d;
            stop_q     <= stop_d;
            busy_q     <= busy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        phase_d   = phase_q;
        oen_d     = oen_q;
        rx_data_d = rx_data_q;
        rw_d      = rw_q;
        busy_d    = busy_q;
        rx_ena_d  = 1'b0;
        tx_req_d  = 1'b0;
        start_d   = 1'b0;
        stop_d    = 1'b0;

        if (stop_ev) begin
            stop_d  = 1'b1;
            state_d = IDLE;
            oen_d   = 1'b0;
            busy_d  = 1'b0;
            phase_d = 1'b0;
        end else if (start_ev) begin
            start_d  = 1'b1;
            state_d  = GET_ADDR;
            bitcnt_d = '0;
            shift_d  = '0;
            oen_d    = 1'b0;
            phase_d  = 1'b0;
        end else begin
            unique case (state_q)
                GET_ADDR: if (scl_rise) begin
                    shift_d  = in_byte;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        if (in_byte[7:1] == DEV_ADDR) begin
                            rw_d     = in_byte[0];
                            busy_d   = 1'b1;
                            tx_req_d = in_byte[0];
                            phase_d  = 1'b0;
                            state_d  = ACK_ADDR;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end
                end
                // phase_q marks the second fall: the end of the ACK slot.
                ACK_ADDR: if (scl_fall) begin
                    if (!phase_q) begin
                        oen_d   = 1'b1;
                        phase_d = 1'b1;
                    end else begin
                        phase_d  = 1'b0;
                        bitcnt_d = '0;
                        if (rw_q) begin
                            shift_d = tx_data;
                            oen_d   = ~tx_data[7];
                            state_d = TX_BYTE;
                        end else begin
                            oen_d   = 1'b0;
                            state_d = RX_BYTE;
                        end
                    end
                end
                RX_BYTE: if (scl_rise) begin
                    shift_d  = in_byte;
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        rx_data_d = in_byte;
                        rx_ena_d  = 1'b1;
                        phase_d   = 1'b0;
                        state_d   = ACK_RX;
                    end
                end
                ACK_RX: if (scl_fall) begin
                    if (!phase_q) begin
                        oen_d   = 1'b1;
                        phase_d = 1'b1;
                    end else begin
                        oen_d    = 1'b0;
                        phase_d  = 1'b0;
                        bitcnt_d = '0;
                        state_d  = RX_BYTE;
                    end
                end
                TX_BYTE: if (scl_fall) begin
                    if (bitcnt_q == 3'd7) begin
                        oen_d   = 1'b0;
                        phase_d = 1'b0;
                        state_d = WAIT_ACK;
                    end else begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        bitcnt_d = bitcnt_q + 3'd1;
                        oen_d    = ~shift_q[6];
                    end
                end
                // phase_q set once the master ACKed; the next fall reloads the shifter.
                WAIT_ACK: begin
                    if (scl_rise && !phase_q) begin
                        if (!sda_s) begin
                            tx_req_d = 1'b1;
                            phase_d  = 1'b1;
                        end else begin
                            busy_d  = 1'b0;
                            state_d = IDLE;
                        end
                    end else if (scl_fall && phase_q) begin
                        shift_d  = tx_data;
                        oen_d    = ~tx_data[7];
                        bitcnt_d = '0;
                        phase_d  = 1'b0;
                        state_d  = TX_BYTE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_o     = 1'b0;
    assign sda_oen   = oen_q;
    assign tx_req    = tx_req_q;
    assign rx_data   = rx_data_q;
    assign rx_ena    = rx_ena_q;
    assign rw        = rw_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_slave_teddy.sv
// Bench for i2c_slave_teddy: bus-master tasks drive SCL/SDA, a monitor
// scoreboards rx_ena bytes against a queue and tallies event pulses.
module tb_i2c_slave_teddy;

    localparam int Q = 4;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       scl = 1'b1;
    logic       msda = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       sda_bus;
    logic       sda_o, sda_oen, tx_req, rx_ena, rw, start_det, stop_det, busy;
    logic [7:0] rx_data;

    int n_pass = 0;
    int n_total = 0;
    int start_cnt = 0, stop_cnt = 0, txreq_cnt = 0, rxena_cnt = 0;
    bit oen_seen = 1'b0;
    logic [7:0] exp_rx[$];

    assign sda_bus = msda & (sda_oen ? sda_o : 1'b1);

    i2c_slave_teddy #(.DEV_ADDR(7'h50)) dut (
        .clk(clk), .n_rst(n_rst), .scl_i(scl), .sda_i(sda_bus),
        .sda_o(sda_o), .sda_oen(sda_oen), .tx_data(tx_data), .tx_req(tx_req),
        .rx_data(rx_data), .rx_ena(rx_ena), .rw(rw), .start_det(start_det),
        .stop_det(stop_det), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Monitor: pops expected rx bytes whenever the DUT flags one.
    initial begin
        forever begin
            @(negedge clk);
            if (start_det) start_cnt++;
            if (stop_det)  stop_cnt++;
            if (tx_req)    txreq_cnt++;
            if (sda_oen)   oen_seen = 1'b1;
            if (rx_ena) begin
                rxena_cnt++;
                if (exp_rx.size() == 0) begin
                    n_total++;
                    $display("FAIL rx_unexpected: got %0h expected none", rx_data);
                end else begin
                    chk("rx_data", {24'h0, rx_data}, {24'h0, exp_rx.pop_front()});
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bit_x(input logic wb, output logic rb);
        msda = wb; cyc(Q);
        scl = 1'b1; cyc(Q);
        rb = sda_bus; cyc(Q);
        scl = 1'b0; cyc(Q);
    endtask

    task automatic bus_start();
        msda = 1'b1; cyc(Q);
        scl = 1'b1; cyc(Q);
        msda = 1'b0; cyc(Q);
        scl = 1'b0; cyc(Q);
    endtask

    task automatic bus_stop();
        msda = 1'b0; cyc(Q);
        scl = 1'b1; cyc(Q);
        msda = 1'b1; cyc(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_x(b[i], r);
        bit_x(1'b1, ack);
    endtask

    task automatic read_byte(input logic mnack, input logic [7:0] next_tx, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, r);
            d[i] = r;
        end
        tx_data = next_tx;
        bit_x(mnack, r);
    endtask

    initial begin
        logic       ack, r;
        logic [7:0] d;
        int s0, p0, t0, r0;

        // Reset
        cyc(3);
        n_rst = 1'b1;
        cyc(2);
        chk("reset_outputs", {16'h0, sda_oen, busy, rw, tx_req, rx_ena, start_det, stop_det, 1'b0, rx_data}, 32'h0);

        // Write A5, 3C
        exp_rx.push_back(8'hA5); exp_rx.push_back(8'h3C);
        s0 = start_cnt; p0 = stop_cnt; r0 = rxena_cnt;
        bus_start();
        write_byte(8'hA0, ack); chk("wr_addr_ack", ack, 0);
        chk("wr_busy", busy, 1);
        chk("wr_rw", rw, 0);
        write_byte(8'hA5, ack); chk("wr_b1_ack", ack, 0);
        write_byte(8'h3C, ack); chk("wr_b2_ack", ack, 0);
        bus_stop(); cyc(4);
        chk("wr_busy_after_stop", busy, 0);
        chk("wr_start_cnt", start_cnt - s0, 1);
        chk("wr_stop_cnt", stop_cnt - p0, 1);
        chk("wr_rx_cnt", rxena_cnt - r0, 2);

        // Read 96 (ACK), 0F (NACK)
        tx_data = 8'h96; t0 = txreq_cnt;
        bus_start();
        write_byte(8'hA1, ack); chk("rd_addr_ack", ack, 0);
        chk("rd_rw", rw, 1);
        read_byte(1'b0, 8'h0F, d); chk("rd_byte1", d, 8'h96);
        read_byte(1'b1, 8'h00, d); chk("rd_byte2", d, 8'h0F);
        cyc(2);
        chk("rd_oen_after_nack", sda_oen, 0);
        chk("rd_busy_after_nack", busy, 0);
        chk("rd_txreq_cnt", txreq_cnt - t0, 2);
        bus_stop(); cyc(4);

        // Wrong address
        oen_seen = 1'b0; r0 = rxena_cnt;
        bus_start();
        write_byte(8'hB0, ack); chk("wa_addr_nack", ack, 1);
        chk("wa_busy", busy, 0);
        write_byte(8'h55, ack); chk("wa_data_nack", ack, 1);
        bus_stop(); cyc(4);
        chk("wa_oen_never", oen_seen, 0);
        chk("wa_rx_cnt", rxena_cnt - r0, 0);

        // Combined write-then-read with repeated START
        exp_rx.push_back(8'h12);
        tx_data = 8'h77; s0 = start_cnt;
        bus_start();
        write_byte(8'hA0, ack); chk("cb_waddr_ack", ack, 0);
        write_byte(8'h12, ack); chk("cb_reg_ack", ack, 0);
        bus_start();
        write_byte(8'hA1, ack); chk("cb_raddr_ack", ack, 0);
        read_byte(1'b1, 8'h00, d); chk("cb_rd_byte", d, 8'h77);
        bus_stop(); cyc(4);
        chk("cb_start_cnt", start_cnt - s0, 2);
        chk("cb_rx_data_hold", rx_data, 8'h12);

        // STOP after 4 data bits, then a normal address phase
        r0 = rxena_cnt;
        bus_start();
        write_byte(8'hA0, ack); chk("ps_addr_ack", ack, 0);
        bit_x(1'b1, r); bit_x(1'b0, r); bit_x(1'b1, r); bit_x(1'b0, r);
        bus_stop(); cyc(4);
        chk("ps_busy", busy, 0);
        chk("ps_oen", sda_oen, 0);
        chk("ps_rx_cnt", rxena_cnt - r0, 0);
        bus_start();
        write_byte(8'hA0, ack); chk("ps_readdr_ack", ack, 0);
        chk("ps_readdr_busy", busy, 1);
        bus_stop(); cyc(4);

        // Reset while the target drives the address ACK
        bus_start();
        for (int i = 7; i >= 0; i--) bit_x(d[i] & 1'b0 | ((8'hA0 >> i) & 1), r);
        msda = 1'b1; cyc(Q);
        scl = 1'b1; cyc(2);
        chk("rst_pre_oen", sda_oen, 1);
        s0 = start_cnt; p0 = stop_cnt;
        n_rst = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        chk("rst_outputs", {16'h0, sda_oen, busy, rw, tx_req, rx_ena, start_det, stop_det, 1'b0, rx_data}, 32'h0);
        cyc(10);
        chk("rst_no_start", start_cnt - s0, 0);
        chk("rst_no_stop", stop_cnt - p0, 0);
        chk("rst_busy", busy, 0);
        chk("rx_queue_empty", exp_rx.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
